// File: rtl/fifo_cell_ring_if.sv
// Handshake bundle between the cell ring and its producer/consumer.
//   put_req / put_data / put_ack : write side (put_ack is combinational)
//   get_req / get_ack            : read side (get_ack is combinational)
//   get_data / get_valid         : registered read result
// master: producer/consumer side. slave: the ring.
interface fifo_cell_ring_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  put_req;
    logic [DATA_WIDTH-1:0] put_data;
    logic                  put_ack;
    logic                  get_req;
    logic                  get_ack;
    logic [DATA_WIDTH-1:0] get_data;
    logic                  get_valid;

    modport master (
        output put_req, put_data, get_req,
        input  put_ack, get_ack, get_data, get_valid
    );

    modport slave (
        input  put_req, put_data, get_req,
        output put_ack, get_ack, get_data, get_valid
    );
endinterface

// File: rtl/fifo_cell_ring.sv
// fifo_cell_ring: storage stage of a cell-based FIFO.
// N_CELLS data cells, each with its own empty bit. One-hot put and get
// tokens rotate around the ring; a put lands on the cell under put_tok if
// that cell is empty, a get takes the cell under get_tok if it is full.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous reset, active-high
//   bus  : fifo_cell_ring_if.slave (put/get handshake, registered read data)
//   e_o  : per-cell empty bits (1 = empty), registered
//   f_o  : per-cell full bits, ~e_o
module fifo_cell_ring #(
    parameter int N_CELLS    = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_cell_ring_if.slave      bus,
    output logic [N_CELLS-1:0]   e_o,
    output logic [N_CELLS-1:0]   f_o
);

    logic [N_CELLS-1:0]    put_tok;
    logic [N_CELLS-1:0]    get_tok;
    logic [N_CELLS-1:0]    empty;
    logic [DATA_WIDTH-1:0] cells [N_CELLS];

    logic                  put_hit;
    logic                  get_hit;
    logic                  put_ack;
    logic                  get_ack;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [N_CELLS-1:0]    empty_next;

    logic [DATA_WIDTH-1:0] get_data_p1;
    logic                  vld_p1;

    function automatic logic [N_CELLS-1:0] rotl(input logic [N_CELLS-1:0] tok);
        return {tok[N_CELLS-2:0], tok[N_CELLS-1]};
    endfunction

    // Tokens are one-hot, so reducing the masked empty vector selects the
    // state of exactly the cell under each token. When both tokens sit on
    // the same cell, that cell is either empty or full, so at most one of
    // the two hits -- this is what arbitrates the same-cell collision.
    assign put_hit = |(put_tok & empty);
    assign get_hit = |(get_tok & ~empty);
    assign put_ack = bus.put_req & put_hit;
    assign get_ack = bus.get_req & get_hit;

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < N_CELLS; i++) begin
            if (get_tok[i]) begin
                rd_word = rd_word | cells[i];
            end
        end
    end

    // Put and get never touch the same cell in one cycle, so clearing and
    // setting can be combined without a priority question.
    always_comb begin
        empty_next = empty;
        if (put_ack) begin
            empty_next = empty_next & ~put_tok;
        end
        if (get_ack) begin
            empty_next = empty_next | get_tok;
        end
    end

    // ---- stage p0 -> p1: cell state, tokens and read register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            put_tok     <= {{(N_CELLS-1){1'b0}}, 1'b1};
            get_tok     <= {{(N_CELLS-1){1'b0}}, 1'b1};
            empty       <= '1;
            get_data_p1 <= '0;
            vld_p1      <= 1'b0;
        end else begin
            empty  <= empty_next;
            vld_p1 <= get_ack;
            if (put_ack) begin
                put_tok <= rotl(put_tok);
            end
            if (get_ack) begin
                get_tok     <= rotl(get_tok);
                get_data_p1 <= rd_word;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CELLS; i++) begin
                cells[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CELLS; i++) begin
                if (put_ack && put_tok[i]) begin
                    cells[i] <= bus.put_data;
                end
            end
        end
    end

    assign bus.put_ack   = put_ack;
    assign bus.get_ack   = get_ack;
    assign bus.get_data  = get_data_p1;
    assign bus.get_valid = vld_p1;
    assign e_o           = empty;
    assign f_o           = ~empty;

endmodule

// File: tb/tb_fifo_cell_ring.sv
// Testbench for fifo_cell_ring: directed vectors; read data is checked by a
// scoreboard queue filled when gets are issued and drained by a monitor.
module tb_fifo_cell_ring;

    logic        clk;
    logic        rst;
    logic [15:0] e_o;
    logic [15:0] f_o;

    int total;
    int bad;

    logic [7:0] exp_q [$];

    fifo_cell_ring_if #(.DATA_WIDTH(8)) bus ();

    fifo_cell_ring #(.N_CELLS(16), .DATA_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .e_o (e_o),
        .f_o (f_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle of stimulus: drive at negedge, check acks mid-cycle, queue
    // the expected word if a get should be accepted, return just after the edge.
    task automatic step(input logic p, input logic [7:0] pd, input logic g,
                        input logic exp_p, input logic exp_g, input logic [7:0] exp_w,
                        input string tag);
        @(negedge clk);
        bus.put_req  = p;
        bus.put_data = pd;
        bus.get_req  = g;
        #1;
        if (p) chk({tag, " put_ack"}, {31'd0, bus.put_ack}, {31'd0, exp_p});
        if (g) chk({tag, " get_ack"}, {31'd0, bus.get_ack}, {31'd0, exp_g});
        if (g && exp_g) exp_q.push_back(exp_w);
        @(posedge clk);
        #1;
        bus.put_req  = 1'b0;
        bus.get_req  = 1'b0;
        bus.put_data = 8'h00;
    endtask

    task automatic chk_e(input string name, input logic [15:0] exp);
        chk({name, " e_o"}, {16'd0, e_o}, {16'd0, exp});
        chk({name, " f_o"}, {16'd0, f_o}, {16'd0, ~exp});
    endtask

    // Monitor: every valid read word must match the oldest queued expectation.
    always begin
        @(posedge clk);
        #2;
        if (!rst && bus.get_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL read_unexpected: got %h with no word expected", bus.get_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (bus.get_data !== e) begin
                    bad++;
                    $display("FAIL read_data: got %h expected %h", bus.get_data, e);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        bus.put_req  = 1'b0;
        bus.put_data = 8'h00;
        bus.get_req  = 1'b0;
        rst = 1'b1;

        // 1. reset state
        #3;
        chk_e("reset", 16'hFFFF);
        chk("reset get_valid", {31'd0, bus.get_valid}, 32'd0);
        chk("reset get_data", {24'd0, bus.get_data}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step(1, 8'h11, 0, 1, 0, 8'h00, "t1 put");
        chk_e("t1 after put", 16'hFFFE);
        step(0, 8'h00, 1, 0, 1, 8'h11, "t1 get");
        chk_e("t1 after get", 16'hFFFF);

        // 2. write/read 0xA5
        step(1, 8'hA5, 0, 1, 0, 8'h00, "t2 put");
        chk_e("t2 after put", 16'hFFFD);
        step(0, 8'h00, 1, 0, 1, 8'hA5, "t2 get");
        chk_e("t2 after get", 16'hFFFF);
        chk("t2 get_valid", {31'd0, bus.get_valid}, 32'd1);
        chk("t2 get_data", {24'd0, bus.get_data}, 32'h000000A5);
        step(0, 8'h00, 0, 0, 0, 8'h00, "t2 idle");
        chk("t2 valid drop", {31'd0, bus.get_valid}, 32'd0);
        chk("t2 data hold", {24'd0, bus.get_data}, 32'h000000A5);

        // 3. fill from cell 0, overflow, drain
        do_reset();
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 1, 0, 8'h00, "t3 fill");
        chk_e("t3 full", 16'h0000);
        step(1, 8'hEE, 0, 0, 0, 8'h00, "t3 overflow");
        chk_e("t3 still full", 16'h0000);
        for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0, 1, 8'(i), "t3 drain");
        chk_e("t3 empty", 16'hFFFF);
        step(0, 8'h00, 1, 0, 0, 8'h00, "t3 underflow");

        // 4. wrap-around
        do_reset();
        for (int i = 0; i < 10; i++) step(1, 8'(8'h20 + i), 0, 1, 0, 8'h00, "t4 put a");
        for (int i = 0; i < 10; i++) step(0, 8'h00, 1, 0, 1, 8'(8'h20 + i), "t4 get a");
        for (int i = 0; i < 10; i++) step(1, 8'(8'h30 + i), 0, 1, 0, 8'h00, "t4 put b");
        chk_e("t4 wrapped", 16'h03F0);
        for (int i = 0; i < 10; i++) step(0, 8'h00, 1, 0, 1, 8'(8'h30 + i), "t4 get b");
        chk_e("t4 empty", 16'hFFFF);

        // 5. simultaneous events (both tokens start at cell 4)
        step(1, 8'h41, 0, 1, 0, 8'h00, "t5 seed");
        chk_e("t5 one word", 16'hFFEF);
        step(1, 8'h42, 1, 1, 1, 8'h41, "t5 both");
        chk_e("t5 both", 16'hFFDF);
        step(0, 8'h00, 1, 0, 1, 8'h42, "t5 drain");
        step(1, 8'h43, 1, 1, 0, 8'h00, "t5 empty same cell");
        chk_e("t5 empty same cell", 16'hFFBF);
        for (int i = 0; i < 15; i++) step(1, 8'(8'h50 + i), 0, 1, 0, 8'h00, "t5 fill");
        chk_e("t5 full", 16'h0000);
        step(1, 8'h99, 1, 0, 1, 8'h43, "t5 full same cell");
        chk_e("t5 after full same cell", 16'h0040);
        for (int i = 0; i < 15; i++) step(0, 8'h00, 1, 0, 1, 8'(8'h50 + i), "t5 drain all");
        chk_e("t5 empty", 16'hFFFF);

        // 6. async reset mid-run
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 8'(8'h60 + i), 0, 1, 0, 8'h00, "t6 put");
        step(0, 8'h00, 1, 0, 1, 8'h60, "t6 get");
        chk_e("t6 before reset", 16'hFFE1);
        #2;
        rst = 1'b1;
        #1;
        chk_e("t6 async reset", 16'hFFFF);
        chk("t6 async get_valid", {31'd0, bus.get_valid}, 32'd0);
        chk("t6 async get_data", {24'd0, bus.get_data}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step(0, 8'h00, 1, 0, 0, 8'h00, "t6 get after reset");
        step(1, 8'h77, 0, 1, 0, 8'h00, "t6 put after reset");
        chk_e("t6 put cell0", 16'hFFFE);
        step(0, 8'h00, 1, 0, 1, 8'h77, "t6 get after put");

        step(0, 8'h00, 0, 0, 0, 8'h00, "final idle");
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d words never read, expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
